// File: rtl/mpc_mac_pkg.sv
// mpc_mac_pkg: shared widths, FSM state type and round-shift helper
// for the MPC multiply-accumulate pipeline.
package mpc_mac_pkg;

    localparam int A_W_DEF   = 21;
    localparam int B_W_DEF   = 7;
    localparam int ACC_W_DEF = 40;
    localparam int OUT_W_DEF = 29;
    localparam int SHIFT_DEF = 0;

    // Container width for rounding; wide enough that the +half never wraps.
    localparam int RS_W = 64;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    // Round-half-up arithmetic right shift on an RS_W-bit signed value.
    function automatic logic signed [RS_W-1:0] round_shift(
        input logic signed [RS_W-1:0] v,
        input int unsigned            sh
    );
        logic signed [RS_W-1:0] half;
        logic signed [RS_W-1:0] r;
        half = 1;
        r    = v;
        if (sh != 0) begin
            half = half <<< (sh - 1);
            r    = (v + half) >>> sh;
        end
        return r;
    endfunction

endpackage

// File: rtl/mpc_mac_out_conv.sv
// mpc_mac_out_conv: round, shift and resize accumulator to output width.
// Define MPC_MAC_SAT_EN for saturation; otherwise two's-complement wrap.
module mpc_mac_out_conv
    import mpc_mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int SHIFT = SHIFT_DEF
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [OUT_W-1:0] res,
    output logic                    sat
);

    localparam logic signed [RS_W-1:0] ONE   = 1;
    localparam logic signed [RS_W-1:0] MAX_V = (ONE <<< (OUT_W - 1)) - ONE;
    localparam logic signed [RS_W-1:0] MIN_V = -(ONE <<< (OUT_W - 1));

    logic signed [RS_W-1:0] wide;
    logic signed [RS_W-1:0] rnd;

    // Sign-extend, round-shift, then clamp or wrap into OUT_W bits.
    always_comb begin
        wide = RS_W'(acc);
        rnd  = round_shift(wide, unsigned'(SHIFT));
`ifdef MPC_MAC_SAT_EN
        if (rnd > MAX_V) begin
            res = OUT_W'(MAX_V);
            sat = 1'b1;
        end else if (rnd < MIN_V) begin
            res = OUT_W'(MIN_V);
            sat = 1'b1;
        end else begin
            res = OUT_W'(rnd);
            sat = 1'b0;
        end
`else
        res = OUT_W'(rnd);
        sat = 1'b0;
`endif
    end

endmodule

// File: rtl/mpc_mac_pipe.sv
// mpc_mac_pipe: 4-stage framed signed x unsigned dot-product MAC.
// Saturating output enabled by defining MPC_MAC_SAT_EN.
module mpc_mac_pipe
    import mpc_mac_pkg::*;
#(
    parameter int A_W   = A_W_DEF,
    parameter int B_W   = B_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int SHIFT = SHIFT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             in_valid,
    input  logic             in_first,
    input  logic             in_last,
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    output logic             out_valid,
    output logic [OUT_W-1:0] p,
    output logic             ovf,
    output logic             seq_err
);

    localparam int PW = A_W + B_W + 1;

    // S1
    logic [A_W-1:0] a1_q, a1_d;
    logic [B_W-1:0] b1_q, b1_d;
    logic           v1_q, v1_d, f1_q, f1_d, l1_q, l1_d;
    // S2
    logic signed [PW-1:0] prod2_q, prod2_d;
    logic                 v2_q, v2_d, f2_q, f2_d, l2_q, l2_d;
    // S3
    state_e                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    done3_q, done3_d, err3_q, err3_d;
    // S4
    logic                    out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0] p_q, p_d;
    logic                    ovf_q, ovf_d, err4_q, err4_d;

    logic signed [OUT_W-1:0] conv_res;
    logic                    conv_sat;

    // S1/S2 next values: input capture and product.
    always_comb begin
        a1_d    = a;
        b1_d    = b;
        v1_d    = in_valid;
        f1_d    = in_first;
        l1_d    = in_last;
        prod2_d = PW'($signed(a1_q)) * PW'($signed({1'b0, b1_q}));
        v2_d    = v1_q;
        f2_d    = f1_q;
        l2_d    = l1_q;
    end

    // Framing FSM and accumulator update for a valid S3 sample.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        done3_d = 1'b0;
        err3_d  = 1'b0;
        if (v2_q) begin
            if (f2_q) begin
                acc_d  = ACC_W'(prod2_q);
                err3_d = (state_q == ACCUM);
                if (l2_q) begin
                    done3_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = ACCUM;
                end
            end else if (state_q == ACCUM) begin
                acc_d = acc_q + ACC_W'(prod2_q);
                if (l2_q) begin
                    done3_d = 1'b1;
                    state_d = IDLE;
                end
            end else begin
                err3_d = 1'b1;
            end
        end
    end

    mpc_mac_out_conv #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_conv (
        .acc (acc_q),
        .res (conv_res),
        .sat (conv_sat)
    );

    // S4 next values: p only moves on a completed vector.
    always_comb begin
        out_valid_d = done3_q;
        p_d         = done3_q ? conv_res : p_q;
        ovf_d       = done3_q & conv_sat;
        err4_d      = err3_q;
    end

    // Pipeline registers; rst beats ce, ce low freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            a1_q        <= '0;
            b1_q        <= '0;
            v1_q        <= 1'b0;
            f1_q        <= 1'b0;
            l1_q        <= 1'b0;
            prod2_q     <= '0;
            v2_q        <= 1'b0;
            f2_q        <= 1'b0;
            l2_q        <= 1'b0;
            state_q     <= IDLE;
            acc_q       <= '0;
            done3_q     <= 1'b0;
            err3_q      <= 1'b0;
            out_valid_q <= 1'b0;
            p_q         <= '0;
            ovf_q       <= 1'b0;
            err4_q      <= 1'b0;
        end else if (ce) begin
            a1_q        <= a1_d;
            b1_q        <= b1_d;
            v1_q        <= v1_d;
            f1_q        <= f1_d;
            l1_q        <= l1_d;
            prod2_q     <= prod2_d;
            v2_q        <= v2_d;
            f2_q        <= f2_d;
            l2_q        <= l2_d;
            state_q     <= state_d;
            acc_q       <= acc_d;
            done3_q     <= done3_d;
            err3_q      <= err3_d;
            out_valid_q <= out_valid_d;
            p_q         <= p_d;
            ovf_q       <= ovf_d;
            err4_q      <= err4_d;
        end
    end

    assign out_valid = out_valid_q;
    assign p         = p_q;
    assign ovf       = ovf_q;
    assign seq_err   = err4_q;

endmodule

// File: tb/tb_mpc_mac_pipe.sv
// tb_mpc_mac_pipe: directed vectors for mpc_mac_pipe (default and
// SHIFT=2 instances); expected overflow result follows MPC_MAC_SAT_EN.
module tb_mpc_mac_pipe;

    logic clk = 1'b0;
    logic rst, ce, in_valid, in_first, in_last;
    logic signed [20:0] a;
    logic [6:0] b;
    logic out_valid, ovf, seq_err;
    logic signed [28:0] p;
    logic out_valid_s, ovf_s, seq_err_s;
    logic signed [28:0] p_s;

    int n_tests = 0;
    int n_fail  = 0;
    int ov_cnt  = 0;
    int se_cnt  = 0;
    logic signed [28:0] last_p = '0;
    logic last_ovf = 1'b0;
    logic ce_at_edge = 1'b0;

    always #5 clk = ~clk;

    mpc_mac_pipe dut (
        .clk(clk), .rst(rst), .ce(ce),
        .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .a(a), .b(b),
        .out_valid(out_valid), .p(p), .ovf(ovf), .seq_err(seq_err)
    );

    mpc_mac_pipe #(.SHIFT(2)) dut_s (
        .clk(clk), .rst(rst), .ce(ce),
        .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .a(a), .b(b),
        .out_valid(out_valid_s), .p(p_s), .ovf(ovf_s), .seq_err(seq_err_s)
    );

    // Pulse counters; outputs only change on ce-enabled edges.
    always @(posedge clk) ce_at_edge <= ce;
    always @(negedge clk) begin
        if (ce_at_edge && !rst) begin
            if (out_valid) begin
                ov_cnt   = ov_cnt + 1;
                last_p   = p;
                last_ovf = ovf;
            end
            if (seq_err) se_cnt = se_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint got,
                         input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic f, input logic l,
                         input logic signed [20:0] av, input logic [6:0] bv);
        in_valid = v;
        in_first = f;
        in_last  = l;
        a        = av;
        b        = bv;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    typedef struct {
        logic signed [20:0] a;
        logic [6:0]         b;
        bit                 shf;
        logic signed [28:0] exp;
    } vec_t;

    vec_t tv[8];

    int lat, ov0, se0;
    logic signed [28:0] got_p;
    logic got_ovf;
    logic signed [28:0] exp_ovp;
    logic exp_ovf;

    initial begin
        tv[0] = '{a: -21'sd3,      b: 7'd5,   shf: 1'b0, exp: -29'sd15};
        tv[1] = '{a: 21'sd7,       b: 7'd1,   shf: 1'b1, exp: 29'sd2};
        tv[2] = '{a: -21'sd7,      b: 7'd1,   shf: 1'b1, exp: -29'sd2};
        tv[3] = '{a: 21'sd6,       b: 7'd1,   shf: 1'b1, exp: 29'sd2};
        tv[4] = '{a: -21'sd3,      b: 7'd5,   shf: 1'b1, exp: -29'sd4};
        tv[5] = '{a: 21'sd1048575, b: 7'd127, shf: 1'b0, exp: 29'sd133169025};
        tv[6] = '{a: -21'sd1048576, b: 7'd127, shf: 1'b0, exp: -29'sd133169152};
        tv[7] = '{a: 21'sd12345,   b: 7'd0,   shf: 1'b0, exp: 29'sd0};

        rst = 1'b1;
        ce  = 1'b1;
        idle();
        drain(3);
        check("reset out_valid", longint'(out_valid), 0);
        check("reset p", longint'(p), 0);
        check("reset ovf", longint'(ovf), 0);
        check("reset seq_err", longint'(seq_err), 0);
        rst = 1'b0;
        tick();

        // Single-element vectors: latency, value, ovf.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b1, tv[i].a, tv[i].b);
            tick();
            idle();
            lat = 0;
            got_p = '0;
            got_ovf = 1'b0;
            for (int k = 2; k <= 8; k++) begin
                tick();
                if (out_valid && lat == 0) begin
                    lat = k;
                    got_p = tv[i].shf ? p_s : p;
                    got_ovf = tv[i].shf ? ovf_s : ovf;
                end
            end
            check($sformatf("single[%0d] latency", i), lat, 4);
            check($sformatf("single[%0d] p", i), got_p, tv[i].exp);
            check($sformatf("single[%0d] ovf", i), longint'(got_ovf), 0);
        end

        // Back-to-back single-element vectors, no bubble.
        drive(1'b1, 1'b1, 1'b1, 21'sd2, 7'd3);
        tick();
        drive(1'b1, 1'b1, 1'b1, -21'sd4, 7'd5);
        tick();
        idle();
        tick();
        tick();
        check("b2b first valid", longint'(out_valid), 1);
        check("b2b first p", longint'(p), 6);
        tick();
        check("b2b second valid", longint'(out_valid), 1);
        check("b2b second p", longint'(p), -20);
        tick();
        check("b2b valid drops", longint'(out_valid), 0);
        check("b2b p holds", longint'(p), -20);

        // Vector with idle gaps.
        ov0 = ov_cnt;
        se0 = se_cnt;
        drive(1'b1, 1'b1, 1'b0, 21'sd100, 7'd2);
        tick();
        idle();
        tick();
        drive(1'b1, 1'b0, 1'b0, -21'sd200, 7'd3);
        tick();
        idle();
        tick();
        drive(1'b1, 1'b0, 1'b1, 21'sd300, 7'd127);
        tick();
        idle();
        drain(8);
        check("gap pulses", ov_cnt - ov0, 1);
        check("gap p", longint'(last_p), 37700);
        check("gap seq_err", se_cnt - se0, 0);

        // Overflow: three large negative products.
`ifdef MPC_MAC_SAT_EN
        exp_ovp = -29'sd268435456;
        exp_ovf = 1'b1;
`else
        exp_ovp = 29'sd137363456;
        exp_ovf = 1'b0;
`endif
        ov0 = ov_cnt;
        drive(1'b1, 1'b1, 1'b0, -21'sd1048576, 7'd127);
        tick();
        drive(1'b1, 1'b0, 1'b0, -21'sd1048576, 7'd127);
        tick();
        drive(1'b1, 1'b0, 1'b1, -21'sd1048576, 7'd127);
        tick();
        idle();
        drain(6);
        check("ovf pulses", ov_cnt - ov0, 1);
        check("ovf p", longint'(last_p), longint'(exp_ovp));
        check("ovf flag", longint'(last_ovf), longint'(exp_ovf));
        check("ovf flag pulse", longint'(ovf), 0);

        // Sample without first while IDLE.
        ov0 = ov_cnt;
        se0 = se_cnt;
        drive(1'b1, 1'b0, 1'b1, 21'sd9, 7'd9);
        tick();
        idle();
        drain(6);
        check("orphan seq_err", se_cnt - se0, 1);
        check("orphan no output", ov_cnt - ov0, 0);

        // New first mid-vector: only the second vector counts.
        ov0 = ov_cnt;
        se0 = se_cnt;
        drive(1'b1, 1'b1, 1'b0, 21'sd10, 7'd1);
        tick();
        drive(1'b1, 1'b1, 1'b0, 21'sd5, 7'd2);
        tick();
        drive(1'b1, 1'b0, 1'b1, 21'sd3, 7'd3);
        tick();
        idle();
        drain(6);
        check("refirst seq_err", se_cnt - se0, 1);
        check("refirst pulses", ov_cnt - ov0, 1);
        check("refirst p", longint'(last_p), 19);

        // rst after the second of three samples aborts the vector.
        ov0 = ov_cnt;
        se0 = se_cnt;
        drive(1'b1, 1'b1, 1'b0, 21'sd50, 7'd1);
        tick();
        drive(1'b1, 1'b0, 1'b0, 21'sd60, 7'd1);
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst clears p", longint'(p), 0);
        drive(1'b1, 1'b1, 1'b1, 21'sd4, 7'd4);
        tick();
        idle();
        drain(6);
        check("rst pulses", ov_cnt - ov0, 1);
        check("rst p", longint'(last_p), 16);
        check("rst seq_err", se_cnt - se0, 0);

        // ce low for 5 cycles mid-pipeline stretches latency by 5.
        drive(1'b1, 1'b1, 1'b0, 21'sd1, 7'd1);
        tick();
        drive(1'b1, 1'b0, 1'b0, 21'sd2, 7'd1);
        tick();
        drive(1'b1, 1'b0, 1'b1, 21'sd3, 7'd1);
        tick();
        idle();
        ce = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 6) ce = 1'b1;
            tick();
            if (out_valid && lat == 0) lat = k;
            if (lat != 0) break;
        end
        check("ce latency", lat, 8);
        check("ce p", longint'(p), 6);
        ce = 1'b0;
        tick();
        tick();
        check("ce hold valid", longint'(out_valid), 1);
        check("ce hold p", longint'(p), 6);
        ce = 1'b1;
        tick();
        check("ce resume valid", longint'(out_valid), 0);
        check("ce resume p", longint'(p), 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mpc_mac_pipe.md
# mpc_mac_pipe

Parametrised, pipelined signed-by-unsigned multiply-accumulate unit for the MPC datapath. It generalises the fixed 21s×7u DSP48 multiplier family: operand, accumulator and output widths are configurable, the output stage has a programmable right-shift with rounding, and framed dot-product accumulation uses valid/first/last flags. It sits between the matrix-coefficient ROM readout and the QP solver update stage. It computes one dot product per framed input vector.

## Interface
- A_W, 21, signed operand width
- B_W, 7, unsigned operand width (zero-extended by one bit before multiply)
- ACC_W, 40, signed accumulator width; must be ≥ A_W+B_W+1
- OUT_W, 29, signed result width
- SHIFT, 0, arithmetic right shift applied at output (0..ACC_W-1)
- clk  in  1  single clock; all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- ce  in  1  clock enable; low freezes every register, including flags
- in_valid  in  1  sample present this cycle
- in_first  in  1  sample opens a vector; qualified by in_valid
- in_last  in  1  sample closes a vector; qualified by in_valid
- a  in  A_W  signed operand
- b  in  B_W  unsigned operand
- out_valid  out  1  p/ovf hold a completed dot product
- p  out  OUT_W  signed result
- ovf  out  1  result was saturated (see Configuration)
- seq_err  out  1  one-cycle framing-error pulse

## Operation
- Pipeline with four stages, each advancing only when ce=1:
  - S1: register a, b, valid, first, last.
  - S2: product = a × $signed({1'b0,b}), A_W+B_W+1 bits; flags forwarded.
  - S3: accumulator update plus framing FSM.
  - S4: output conversion and registration.
- FSM states:
  - IDLE: no open vector.
  - ACCUM: vector open.
- FSM transitions on a valid S3 sample:
  - first=1: acc ← sign-extended product. Go to ACCUM; if already in ACCUM, also pulse seq_err (the old vector is discarded).
  - first=0 in ACCUM: acc ← acc + product, wrapping in ACC_W.
  - first=0 in IDLE: sample dropped; seq_err pulses.
  - last=1 (on an accepted sample): emit the accumulated result to S4 and return to IDLE.
  - first=1 and last=1 together: single-element vector; result = product.
- Invalid cycles (in_valid=0) inside a vector are gaps: the accumulator holds.
- Output conversion:
  - If SHIFT>0, add 2^(SHIFT-1), then arithmetic shift right by SHIFT. This is round-half-up.
  - Resize to OUT_W per the Configuration section.
- Reset: all registers are cleared, the FSM goes to IDLE and any open vector is aborted. Outputs after reset: out_valid=0, p=0, ovf=0, seq_err=0.

## Timing
- Latency: a valid sample with last=1 presented at edge t gives out_valid=1 after edge t+4, counting ce-enabled edges only.
- out_valid, ovf and seq_err are one-cycle pulses while ce=1. With ce=0 all outputs hold their values.
- p holds its value until the next completed vector.
- Throughput: one sample per cycle, with back-to-back vectors. A first sample may immediately follow a last sample with no bubble.
- rst has priority over ce. A result already in flight when rst is asserted is lost.

## Configuration
- MPC_MAC_SAT_EN defined:
  - Values above 2^(OUT_W-1)-1 clamp to that maximum.
  - Values below -2^(OUT_W-1) clamp to that minimum.
  - ovf=1 with out_valid whenever a value was clamped.
- MPC_MAC_SAT_EN undefined:
  - The low OUT_W bits are taken, i.e. two's-complement wrap.
  - ovf is tied to 0.

## Structure
- Shared package mpc_mac_pkg holds:
  - the default width constants;
  - the FSM state typedef (IDLE, ACCUM);
  - a round-shift function parameterised by width.
- One sub-module, mpc_mac_out_conv: combinational round, shift and saturate/wrap, feeding the S4 register. The MPC_MAC_SAT_EN switch lives in this sub-module.

## Test plan
- Single element, defaults: a=-3, b=5, first=last=1 → 4 edges later out_valid=1, p=-15, ovf=0.
- Vector with gaps: a={100,-200,300}, b={2,3,127}, with one idle cycle between samples → p=37700, exactly one out_valid pulse.
- Overflow: a=-1048576, b=127, three samples → with MPC_MAC_SAT_EN, p=-268435456 and ovf=1; without it, p=137363456 and ovf=0.
- Rounding, SHIFT=2: single elements a=7,b=1 → p=2; a=-7,b=1 → p=-2; a=6,b=1 → p=2.
- Framing errors:
  - A sample without first while IDLE → seq_err pulse and no output.
  - A new first mid-vector → seq_err pulse; the result covers only the second vector.
- rst and ce:
  - Assert rst after the second of three samples; next vector {a=4,b=4} single element → p=16.
  - Hold ce=0 for 5 cycles mid-pipeline → latency extends by 5 cycles and the results are unchanged.
